// File: rtl/btn_evt_arbiter.sv
// btn_evt_arbiter: round-robin arbiter of per-button short/long press events into an event FIFO (optional drop counter: BTN_ARB_DROP_CNT_EN)
module btn_evt_arbiter #(
  parameter int N_BTN      = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] short_i,
  input  logic [N_BTN-1:0] long_i,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_long,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [7:0]       drop_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [N_BTN-1:0] pend_s, pend_l, gnt_s, gnt_l, cap_s, drop;
  logic [ID_W-1:0]  rr_ptr, gid, idx;
  logic             gnt, glong, pop;
  logic [ID_W:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  // first pending button at or after rr_ptr wins, but only while the FIFO has room
  always_comb begin
    gnt = 1'b0;
    gid = '0;
    idx = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_BTN);
      if (pend_l[idx] | pend_s[idx]) begin
        gnt = count < CW'(FIFO_DEPTH);
        gid = idx;
      end
    end
    glong = pend_l[gid];
  end
  assign gnt_l     = {N_BTN{gnt & glong}} & (N_BTN'(1) << gid);
  assign gnt_s     = {N_BTN{gnt & ~glong}} & (N_BTN'(1) << gid);
  assign cap_s     = short_i & ~long_i;
  assign drop      = (long_i & pend_l & ~gnt_l) | (cap_s & pend_s & ~gnt_s);
  assign evt_valid = count != '0;
  assign pop       = evt_valid & evt_ready;
  assign evt_id    = evt_valid ? mem[rd_ptr][ID_W:1] : '0;
  assign evt_long  = evt_valid & mem[rd_ptr][0];
  // pending flags, round-robin pointer, FIFO bookkeeping and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_s   <= '0;
      pend_l   <= '0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      pend_l   <= (pend_l & ~gnt_l) | long_i;
      pend_s   <= (pend_s & ~gnt_s) | cap_s;
      rr_ptr   <= gnt ? ID_W'((int'(gid) + 1) % N_BTN) : rr_ptr;
      wr_ptr   <= wr_ptr + PW'(gnt);
      rd_ptr   <= rd_ptr + PW'(pop);
      count    <= count + CW'(gnt) - CW'(pop);
      overflow <= (|drop) | (overflow & ~clr_ovf);
    end
  end
  // event storage; contents are meaningless outside the count window so no reset
  always_ff @(posedge clk) begin
    if (rst_n && gnt) mem[wr_ptr] <= {gid, glong};
  end
`ifdef BTN_ARB_DROP_CNT_EN
  logic [3:0] ndrop;
  logic [8:0] dsum;
  // number of events dropped this cycle (at most one per button)
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < N_BTN; i++) ndrop = ndrop + 4'(drop[i]);
  end
  assign dsum = {1'b0, drop_cnt} + 9'(ndrop);
  // saturating drop counter; a clear still records drops of the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= '0;
    else drop_cnt <= clr_ovf ? 8'(ndrop) : (dsum[8] ? 8'hff : dsum[7:0]);
  end
`else
  assign drop_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_btn_evt_arbiter.sv
// tb_btn_evt_arbiter: directed scenarios plus randomized run against a queue-based event model
module tb_btn_evt_arbiter;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 0, rst_n = 0, evt_ready = 0, clr_ovf = 0;
  logic [3:0] short_i = 0, long_i = 0;
  logic evt_valid, evt_long, overflow;
  logic [1:0] evt_id;
  logic [7:0] drop_cnt;
  int n_chk = 0, n_err = 0;
  int q_id[$];
  bit q_l[$];
  bit mp_s[N], mp_l[N];
  int mrr, mdrop;
  bit movf;

  btn_evt_arbiter #(.N_BTN(4), .ID_W(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .short_i(short_i), .long_i(long_i),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_long(evt_long),
    .overflow(overflow), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic mstep(input bit r, input logic [3:0] s, input logic [3:0] l, input bit rd, input bit c);
    int g, nd;
    bit gl;
    if (!r) begin
      q_id.delete();
      q_l.delete();
      foreach (mp_s[i]) begin mp_s[i] = 0; mp_l[i] = 0; end
      mrr = 0; movf = 0; mdrop = 0;
      return;
    end
    g = -1; nd = 0;
    if (q_id.size() < D)
      for (int k = 0; k < N; k++)
        if (mp_l[(mrr + k) % N] || mp_s[(mrr + k) % N]) begin g = (mrr + k) % N; break; end
    if (q_id.size() != 0 && rd) begin void'(q_id.pop_front()); void'(q_l.pop_front()); end
    if (g >= 0) begin
      gl = mp_l[g];
      q_id.push_back(g);
      q_l.push_back(gl);
      if (gl) mp_l[g] = 0; else mp_s[g] = 0;
      mrr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++)
      if (l[i]) begin if (mp_l[i]) nd++; mp_l[i] = 1; end
      else if (s[i]) begin if (mp_s[i]) nd++; mp_s[i] = 1; end
    if (nd > 0) movf = 1; else if (c) movf = 0;
`ifdef BTN_ARB_DROP_CNT_EN
    mdrop = c ? nd : ((mdrop + nd > 255) ? 255 : mdrop + nd);
`endif
  endtask

  task automatic cyc(input bit r, input logic [3:0] s, input logic [3:0] l, input bit rd, input bit c);
    rst_n = r; short_i = s; long_i = l; evt_ready = rd; clr_ovf = c;
    mstep(r, s, l, rd, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 4'hf, 4'hf, 1, 0);
    n_chk++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    n_chk++; if (evt_id !== 2'd0) begin n_err++; $display("FAIL reset_id got %0d want 0", evt_id); end
    n_chk++; if (evt_long !== 1'b0) begin n_err++; $display("FAIL reset_long got %b want 0", evt_long); end
    n_chk++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_latency;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 4'b0100, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL lat_c1_valid got %b want 0", evt_valid); end
    cyc(1, 0, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_long !== 1'b0)
      begin n_err++; $display("FAIL lat_c2 got v=%b id=%0d l=%b want v=1 id=2 l=0", evt_valid, evt_id, evt_long); end
    cyc(1, 0, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL lat_c3_valid got %b want 0", evt_valid); end
  endtask

  task automatic test_back_to_back;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 4'b1111, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 0, 0);
      n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd0)
        begin n_err++; $display("FAIL fill_hold%0d got v=%b id=%0d want v=1 id=0", k, evt_valid, evt_id); end
    end
    for (int k = 1; k < 4; k++) begin
      cyc(1, 0, 0, 1, 0);
      n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'(k))
        begin n_err++; $display("FAIL drain%0d got v=%b id=%0d want v=1 id=%0d", k, evt_valid, evt_id, k); end
    end
    cyc(1, 0, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", evt_valid); end
  endtask

  task automatic test_round_robin;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 4'b0010, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 4'b1001, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd3)
      begin n_err++; $display("FAIL rr_first got v=%b id=%0d want v=1 id=3", evt_valid, evt_id); end
    cyc(1, 0, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd0)
      begin n_err++; $display("FAIL rr_second got v=%b id=%0d want v=1 id=0", evt_valid, evt_id); end
    cyc(1, 0, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rr_empty got %b want 0", evt_valid); end
  endtask

  task automatic test_short_long;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 4'b0010, 4'b0010, 0, 0);
    cyc(1, 0, 0, 0, 0);
    n_chk++; if (evt_id !== 2'd1 || evt_long !== 1'b1)
      begin n_err++; $display("FAIL sl_long got id=%0d l=%b want id=1 l=1", evt_id, evt_long); end
    cyc(1, 4'b0010, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_long !== 1'b0)
      begin n_err++; $display("FAIL sl_short got v=%b id=%0d l=%b want v=1 id=1 l=0", evt_valid, evt_id, evt_long); end
    cyc(1, 0, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b0 || overflow !== 1'b0)
      begin n_err++; $display("FAIL sl_end got v=%b ovf=%b want v=0 ovf=0", evt_valid, overflow); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_d;
`ifdef BTN_ARB_DROP_CNT_EN
    exp_d = 8'd1;
`else
    exp_d = 8'd0;
`endif
    cyc(0, 0, 0, 0, 0);
    cyc(1, 4'b1111, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 0);
    cyc(1, 4'b0001, 0, 0, 0);
    n_chk++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_first got %b want 0", overflow); end
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 4'b0001, 0, 0, 0);
    n_chk++; if (overflow !== 1'b1 || drop_cnt !== exp_d)
      begin n_err++; $display("FAIL ovf_drop got ovf=%b cnt=%0d want ovf=1 cnt=%0d", overflow, drop_cnt, exp_d); end
    cyc(1, 0, 0, 0, 1);
    n_chk++; if (overflow !== 1'b0 || drop_cnt !== 8'd0)
      begin n_err++; $display("FAIL ovf_clr got ovf=%b cnt=%0d want ovf=0 cnt=0", overflow, drop_cnt); end
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd0)
      begin n_err++; $display("FAIL ovf_head got v=%b id=%0d want v=1 id=0", evt_valid, evt_id); end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 4'b0111, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(1, 4'b1001, 0, 0, 0);
    cyc(1, 4'b1001, 0, 0, 0);
    n_chk++; if (overflow !== 1'b1) begin n_err++; $display("FAIL mid_pre_ovf got %b want 1", overflow); end
    cyc(0, 0, 0, 1, 0);
    n_chk++; if (evt_valid !== 1'b0 || overflow !== 1'b0)
      begin n_err++; $display("FAIL mid_rst got v=%b ovf=%b want v=0 ovf=0", evt_valid, overflow); end
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 1, 0);
      n_chk++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale%0d got %b want 0", k, evt_valid); end
    end
  endtask

  task automatic test_random;
    bit r, rd, c;
    logic [3:0] s, l;
    int e_id;
    bit e_v, e_l;
    cyc(0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      r  = $urandom_range(199) != 0;
      s  = ($urandom_range(2) == 0) ? 4'($urandom) : 4'd0;
      l  = ($urandom_range(4) == 0) ? 4'($urandom) : 4'd0;
      rd = (n % 200 < 100) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      c  = $urandom_range(19) == 0;
      cyc(r, s, l, rd, c);
      e_v  = q_id.size() != 0;
      e_id = e_v ? q_id[0] : 0;
      e_l  = e_v ? q_l[0] : 1'b0;
      n_chk++; if (evt_valid !== e_v || evt_id !== 2'(e_id) || evt_long !== e_l)
        begin n_err++; $display("FAIL rnd_evt@%0d got v=%b id=%0d l=%b want v=%b id=%0d l=%b", n, evt_valid, evt_id, evt_long, e_v, e_id, e_l); end
      n_chk++; if (overflow !== movf || drop_cnt !== 8'(mdrop))
        begin n_err++; $display("FAIL rnd_ovf@%0d got ovf=%b cnt=%0d want ovf=%b cnt=%0d", n, overflow, drop_cnt, movf, mdrop); end
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_back_to_back;
    test_round_robin;
    test_short_long;
    test_overflow;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
